// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helper for the configuration chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StCheck
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One serial step of CRC-8; the feedback term is the MSB xor the incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8_ser.sv
// Bit-serial CRC-8 accumulator with synchronous clear and step enable.
module ccff_crc8_ser
    import ccff_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_in_i,
    output logic [7:0] crc_out_o
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_step(crc_q, bit_in_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a word stream into a config chain and optionally re-reads it by rotation,
// comparing load and readback CRC-8 values.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 22,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk_i,
    input  logic              prog_reset_i,
    input  logic              start_i,
    input  logic              verify_en_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              ccff_head_o,
    output logic              ccff_shift_en_o,
    input  logic              ccff_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_error_o,
    output logic              cfg_valid_o
);

    localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned WACC_W = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [WACC_W-1:0] NWORDS_C = WACC_W'(NWORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic              wbuf_v_q, wbuf_v_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [WACC_W-1:0] words_acc_q, words_acc_d;
    logic              verify_q, verify_d;
    logic              done_q, done_d;
    logic              cfg_error_q, cfg_error_d;
    logic              cfg_valid_q, cfg_valid_d;

    logic       crc_clr, crc_ld_en, crc_vf_en;
    logic       last_bit, shift_en, head, s_ready;
    logic [7:0] crc_ld, crc_vf;

    // Last bit of the buffered word: word boundary, or the truncated tail of the final word.
    assign last_bit = wbuf_v_q && ((widx_q == LAST_IDX) || (bit_cnt_q == LAST_CNT));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        wbuf_d      = wbuf_q;
        wbuf_v_d    = wbuf_v_q;
        widx_d      = widx_q;
        words_acc_d = words_acc_q;
        verify_d    = verify_q;
        done_d      = 1'b0;
        cfg_error_d = cfg_error_q;
        cfg_valid_d = cfg_valid_q;
        crc_clr     = 1'b0;
        crc_ld_en   = 1'b0;
        crc_vf_en   = 1'b0;
        shift_en    = 1'b0;
        head        = 1'b0;
        s_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StLoad;
                    bit_cnt_d   = '0;
                    wbuf_v_d    = 1'b0;
                    widx_d      = '0;
                    words_acc_d = '0;
                    verify_d    = verify_en_i;
                    cfg_error_d = 1'b0;
                    cfg_valid_d = 1'b0;
                    crc_clr     = 1'b1;
                end
            end
            StLoad: begin
                if (abort_i) begin
                    state_d     = StIdle;
                    wbuf_v_d    = 1'b0;
                    done_d      = 1'b1;
                    cfg_error_d = 1'b1;
                    cfg_valid_d = 1'b0;
                end else begin
                    s_ready = (words_acc_q < NWORDS_C) && (!wbuf_v_q || last_bit);
                    if (wbuf_v_q) begin
                        shift_en  = 1'b1;
                        head      = wbuf_q[widx_q];
                        crc_ld_en = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        widx_d    = last_bit ? '0 : widx_q + 1'b1;
                        if (last_bit) begin
                            wbuf_v_d = 1'b0;
                        end
                    end
                    if (s_ready && s_valid_i) begin
                        wbuf_d      = s_data_i;
                        wbuf_v_d    = 1'b1;
                        widx_d      = '0;
                        words_acc_d = words_acc_q + 1'b1;
                    end
                    if (wbuf_v_q && (bit_cnt_q == LAST_CNT)) begin
                        // bit_cnt is reused to time the rotation.
                        bit_cnt_d = '0;
                        if (verify_q) begin
                            state_d = StVerify;
                        end else begin
                            state_d     = StIdle;
                            done_d      = 1'b1;
                            cfg_valid_d = 1'b1;
                        end
                    end
                end
            end
            StVerify: begin
                if (abort_i) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    cfg_error_d = 1'b1;
                    cfg_valid_d = 1'b0;
                end else begin
                    shift_en  = 1'b1;
                    head      = ccff_tail_i;
                    crc_vf_en = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_CNT) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (crc_vf != crc_ld) begin
                    cfg_error_d = 1'b1;
                end else begin
                    cfg_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge prog_clk_i or posedge prog_reset_i) begin
        if (prog_reset_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            wbuf_q      <= '0;
            wbuf_v_q    <= 1'b0;
            widx_q      <= '0;
            words_acc_q <= '0;
            verify_q    <= 1'b0;
            done_q      <= 1'b0;
            cfg_error_q <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            wbuf_q      <= wbuf_d;
            wbuf_v_q    <= wbuf_v_d;
            widx_q      <= widx_d;
            words_acc_q <= words_acc_d;
            verify_q    <= verify_d;
            done_q      <= done_d;
            cfg_error_q <= cfg_error_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    ccff_crc8_ser u_crc_ld (
        .clk_i     (prog_clk_i),
        .rst_i     (prog_reset_i),
        .clr_i     (crc_clr),
        .en_i      (crc_ld_en),
        .bit_in_i  (head),
        .crc_out_o (crc_ld)
    );

    ccff_crc8_ser u_crc_vf (
        .clk_i     (prog_clk_i),
        .rst_i     (prog_reset_i),
        .clr_i     (crc_clr),
        .en_i      (crc_vf_en),
        .bit_in_i  (ccff_tail_i),
        .crc_out_o (crc_vf)
    );

    assign s_ready_o       = s_ready;
    assign ccff_head_o     = head;
    assign ccff_shift_en_o = shift_en;
    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
    assign cfg_error_o     = cfg_error_q;
    assign cfg_valid_o     = cfg_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 22-flop chain model driven by head/shift_en, table rows,
// hand-written idle corner cases and randomized loads checked against a bit-stream model.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 22;
    localparam int WORD_W    = 8;
    localparam logic [21:0] FLIP_MASK = 22'h000400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, verify_en, abort, s_valid, s_ready;
    logic [7:0]  s_data;
    logic        head, shift_en, tail, busy, done, cfg_error, cfg_valid;
    logic [21:0] chain = '0;
    logic        flip_req;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk_i      (clk),
        .prog_reset_i    (rst),
        .start_i         (start),
        .verify_en_i     (verify_en),
        .abort_i         (abort),
        .s_data_i        (s_data),
        .s_valid_i       (s_valid),
        .s_ready_o       (s_ready),
        .ccff_head_o     (head),
        .ccff_shift_en_o (shift_en),
        .ccff_tail_i     (tail),
        .busy_o          (busy),
        .done_o          (done),
        .cfg_error_o     (cfg_error),
        .cfg_valid_o     (cfg_valid)
    );

    // Chain model: head enters flop 0, tail is the last flop; flip_req injects a bit error.
    always @(posedge clk) begin
        if (shift_en) chain <= {chain[20:0], head} ^ (flip_req ? FLIP_MASK : 22'h0);
        else if (flip_req) chain <= chain ^ FLIP_MASK;
    end
    assign tail = chain[21];

    typedef struct {
        logic [23:0] wv;
        bit          ver;
        int          stall;
        int          restart_at;
        int          flip_at;
        int          abort_at;
        int          reset_at;
        int          e_cyc;
        int          e_sh;
        int          e_acc;
        int          e_done;
        int          e_err;
        int          e_val;
        bit          chk;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // First bit streamed ends up at the tail after CHAIN_LEN shifts.
    function automatic logic [21:0] model_chain(input logic [23:0] wv);
        logic [21:0] c;
        for (int i = 0; i < CHAIN_LEN; i++) c[CHAIN_LEN-1-i] = wv[i];
        return c;
    endfunction

    task automatic do_op(input int id, input vec_t v);
        int          wi, acc, shifts, cycles, done_cnt, stall_left, nh;
        bit          finished;
        logic [21:0] heads, hmask;
        wi = 0; acc = 0; shifts = 0; cycles = 0; done_cnt = 0;
        stall_left = v.stall; finished = 1'b0; heads = '0; hmask = '0;
        @(negedge clk);
        start = 1'b1; verify_en = v.ver;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            start     = (cyc == v.restart_at);
            verify_en = (cyc == v.restart_at) ? !v.ver : v.ver;
            abort     = (shifts == v.abort_at);
            flip_req  = (shifts == v.flip_at);
            if (wi < 3) begin
                s_valid = !(wi == 1 && stall_left > 0);
                s_data  = v.wv[wi*8 +: 8];
            end else begin
                s_valid = 1'b1;
                s_data  = 8'hFF;
            end
            if (shifts == v.reset_at) begin
                #1 rst = 1'b1;
                #1;
                check($sformatf("row%0d reset busy", id), busy, 0);
                check($sformatf("row%0d reset done", id), done, 0);
                check($sformatf("row%0d reset err", id), cfg_error, 0);
                check($sformatf("row%0d reset valid", id), cfg_valid, 0);
                check($sformatf("row%0d reset ready/head/shift", id),
                      {s_ready, head, shift_en}, 0);
            end else begin
                #1;
            end
            if (shift_en) begin
                if (shifts < CHAIN_LEN) heads[shifts] = head;
                shifts++;
            end
            if (s_valid && s_ready) begin
                acc++;
                if (wi < 3) wi++;
            end else if (wi == 1 && stall_left > 0 && s_ready) begin
                stall_left--;
            end
            @(negedge clk);
            cycles++;
            if (done) done_cnt++;
            if (!busy) finished = 1'b1;
        end
        start = 1'b0; abort = 1'b0; flip_req = 1'b0; s_valid = 1'b0; verify_en = 1'b0;
        rst = 1'b0;
        check($sformatf("row%0d finished in budget", id), finished, 1);
        @(negedge clk);
        if (done) done_cnt++;
        nh = (shifts < CHAIN_LEN) ? shifts : CHAIN_LEN;
        for (int i = 0; i < nh; i++) hmask[i] = 1'b1;
        check($sformatf("row%0d cycles", id), cycles, v.e_cyc);
        check($sformatf("row%0d shifts", id), shifts, v.e_sh);
        check($sformatf("row%0d words accepted", id), acc, v.e_acc);
        check($sformatf("row%0d done pulses", id), done_cnt, v.e_done);
        check($sformatf("row%0d cfg_error", id), cfg_error, v.e_err);
        check($sformatf("row%0d cfg_valid", id), cfg_valid, v.e_val);
        check($sformatf("row%0d busy after", id), busy, 0);
        check($sformatf("row%0d head stream", id), heads & hmask, v.wv[21:0] & hmask);
        if (v.chk) check($sformatf("row%0d chain", id), chain, model_chain(v.wv));
    endtask

    initial begin
        vec_t r;
        rst = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; flip_req = 1'b0;

        //          wv           ver stall rst@ flip abrt rst  cyc sh acc dn er vl chk
        tbl[0] = '{24'h153CA5, 1'b0, 0, -1, -1, -1, -1, 23, 22, 3, 1, 0, 1, 1'b1};
        tbl[1] = '{24'h153CA5, 1'b1, 0, -1, -1, -1, -1, 46, 44, 3, 1, 0, 1, 1'b1};
        tbl[2] = '{24'h153CA5, 1'b1, 0, -1, 25, -1, -1, 46, 44, 3, 1, 1, 0, 1'b0};
        tbl[3] = '{24'h153CA5, 1'b0, 3, -1, -1, -1, -1, 26, 22, 3, 1, 0, 1, 1'b1};
        tbl[4] = '{24'h153CA5, 1'b0, 0, -1, -1,  9, -1, 11,  9, 2, 1, 1, 0, 1'b0};
        tbl[5] = '{24'hFF00FF, 1'b1, 0, -1, -1, -1, -1, 46, 44, 3, 1, 0, 1, 1'b1};
        tbl[6] = '{24'h153CA5, 1'b1, 0, -1, -1, -1, 30, 32, 30, 3, 0, 0, 0, 1'b0};
        tbl[7] = '{24'h153CA5, 1'b0, 0,  5, -1, -1, -1, 23, 22, 3, 1, 0, 1, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy/done", {busy, done}, 0);
        check("reset err/valid", {cfg_error, cfg_valid}, 0);
        check("reset ready/head/shift", {s_ready, head, shift_en}, 0);

        for (int i = 0; i < 8; i++) do_op(i, tbl[i]);

        // abort while idle leaves the sticky result alone
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle abort done", done, 0);
        check("idle abort valid", cfg_valid, 1);
        check("idle abort err/busy", {cfg_error, busy}, 0);

        // start and abort together in idle: start wins, then abort the load
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", busy, 1);
        check("start+abort valid cleared", cfg_valid, 0);
        abort = 1'b1;
        #1 check("abort shift_en same cycle", shift_en, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort done/err/busy", {done, cfg_error, busy}, 3'b110);

        for (int i = 0; i < 16; i++) begin
            r.wv = 24'($urandom);
            r.ver = 1'($urandom_range(0, 1));
            r.stall = $urandom_range(0, 4);
            r.restart_at = -1; r.flip_at = -1; r.abort_at = -1; r.reset_at = -1;
            r.e_cyc = 23 + r.stall + (r.ver ? 23 : 0);
            r.e_sh = r.ver ? 2 * CHAIN_LEN : CHAIN_LEN;
            r.e_acc = 3; r.e_done = 1; r.e_err = 0; r.e_val = 1; r.chk = 1'b1;
            do_op(100 + i, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
